// File: rtl/aq_idu_reg_busy_sb.sv
// Register busy scoreboard for the IDU: issue marks the destination busy, writebacks clear it,
// and source lookups report RAW hazards. Optional macro AQ_IDU_SB_WB_BYPASS_EN adds same-cycle wb bypass.
module aq_idu_reg_busy_sb #(
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned WB_PORTS = 2,
  parameter int unsigned SRC_NUM  = 2,
  parameter bit          R0_ZERO  = 1'b1,
  localparam int unsigned REG_NUM = 2**IDX_W
) (
  input  logic                        forever_cpuclk,
  input  logic                        cpurst,
  input  logic                        flush,
  input  logic                        issue_vld,
  input  logic [IDX_W-1:0]            issue_dst_idx,
  input  logic [WB_PORTS-1:0]         wb_vld,
  input  logic [WB_PORTS*IDX_W-1:0]   wb_idx,
  input  logic [SRC_NUM*IDX_W-1:0]    src_idx,
  output logic [SRC_NUM-1:0]          src_busy,
  output logic                        dst_busy,
  output logic [REG_NUM-1:0]          busy_vec,
  output logic [IDX_W:0]              busy_cnt
);

  function automatic logic [REG_NUM-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [REG_NUM-1:0] oh;
    oh      = {REG_NUM{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [REG_NUM-1:0] v);
    logic [IDX_W:0] c;
    c = {(IDX_W+1){1'b0}};
    for (int k = 0; k < int'(REG_NUM); k++) begin
      c = c + {{IDX_W{1'b0}}, v[k]};
    end
    return c;
  endfunction

  logic [REG_NUM-1:0] busy_q, busy_d;
  logic [IDX_W:0]     cnt_q, cnt_d;
  logic [REG_NUM-1:0] clr_s, set_s;
  logic [SRC_NUM-1:0] byp_s;

  // Next table: clears from all wb ports, then the issue set on top so a same-index set wins.
  always_comb begin
    clr_s = {REG_NUM{1'b0}};
    for (int p = 0; p < int'(WB_PORTS); p++) begin
      clr_s = clr_s | (wb_vld[p] ? onehot(wb_idx[p*IDX_W +: IDX_W]) : {REG_NUM{1'b0}});
    end
    set_s = issue_vld ? onehot(issue_dst_idx) : {REG_NUM{1'b0}};
    if (flush) begin
      busy_d = {REG_NUM{1'b0}};
    end else begin
      busy_d = (busy_q & ~clr_s) | set_s;
    end
    busy_d[0] = busy_d[0] & ~R0_ZERO;
    cnt_d     = popcount(busy_d);
  end

`ifdef AQ_IDU_SB_WB_BYPASS_EN
  // Same-cycle writeback hides the hazard from the matching source lookup.
  always_comb begin
    byp_s = {SRC_NUM{1'b0}};
    for (int s = 0; s < int'(SRC_NUM); s++) begin
      for (int p = 0; p < int'(WB_PORTS); p++) begin
        byp_s[s] = byp_s[s] |
                   (wb_vld[p] & (wb_idx[p*IDX_W +: IDX_W] == src_idx[s*IDX_W +: IDX_W]));
      end
    end
  end
`else
  assign byp_s = {SRC_NUM{1'b0}};
`endif

  // Zero-latency lookups against the registered table, masked during reset.
  always_comb begin
    src_busy = {SRC_NUM{1'b0}};
    for (int s = 0; s < int'(SRC_NUM); s++) begin
      src_busy[s] = ~cpurst & busy_q[src_idx[s*IDX_W +: IDX_W]] & ~byp_s[s] &
                    ~(R0_ZERO & (src_idx[s*IDX_W +: IDX_W] == {IDX_W{1'b0}}));
    end
    dst_busy = ~cpurst & busy_q[issue_dst_idx] &
               ~(R0_ZERO & (issue_dst_idx == {IDX_W{1'b0}}));
  end

  // Table and its population count advance together.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      busy_q <= {REG_NUM{1'b0}};
      cnt_q  <= {(IDX_W+1){1'b0}};
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_aq_idu_reg_busy_sb.sv
// Randomized bench for aq_idu_reg_busy_sb: two instances (R0_ZERO=1 and R0_ZERO=0) checked
// against an array model of the busy rules; honours AQ_IDU_SB_WB_BYPASS_EN.
module tb_aq_idu_reg_busy_sb;
  localparam int IDX_W    = 5;
  localparam int WB_PORTS = 2;
  localparam int SRC_NUM  = 2;
  localparam int REG_NUM  = 32;
`ifdef AQ_IDU_SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      cpurst, flush, issue_vld;
  logic [IDX_W-1:0]          issue_dst_idx;
  logic [WB_PORTS-1:0]       wb_vld;
  logic [WB_PORTS*IDX_W-1:0] wb_idx;
  logic [SRC_NUM*IDX_W-1:0]  src_idx;
  logic [SRC_NUM-1:0]        src_busy_a, src_busy_b;
  logic                      dst_busy_a, dst_busy_b;
  logic [REG_NUM-1:0]        busy_vec_a, busy_vec_b;
  logic [IDX_W:0]            busy_cnt_a, busy_cnt_b;

  bit mb [2][REG_NUM];
  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aq_idu_reg_busy_sb #(.IDX_W(IDX_W), .WB_PORTS(WB_PORTS), .SRC_NUM(SRC_NUM), .R0_ZERO(1'b1)) dut (
    .forever_cpuclk(clk), .cpurst(cpurst), .flush(flush), .issue_vld(issue_vld),
    .issue_dst_idx(issue_dst_idx), .wb_vld(wb_vld), .wb_idx(wb_idx), .src_idx(src_idx),
    .src_busy(src_busy_a), .dst_busy(dst_busy_a), .busy_vec(busy_vec_a), .busy_cnt(busy_cnt_a));

  aq_idu_reg_busy_sb #(.IDX_W(IDX_W), .WB_PORTS(WB_PORTS), .SRC_NUM(SRC_NUM), .R0_ZERO(1'b0)) dut_nz (
    .forever_cpuclk(clk), .cpurst(cpurst), .flush(flush), .issue_vld(issue_vld),
    .issue_dst_idx(issue_dst_idx), .wb_vld(wb_vld), .wb_idx(wb_idx), .src_idx(src_idx),
    .src_busy(src_busy_b), .dst_busy(dst_busy_b), .busy_vec(busy_vec_b), .busy_cnt(busy_cnt_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_lookup(input int inst, input logic [IDX_W-1:0] idx);
    if (cpurst) return 1'b0;
    if (inst == 0 && idx == 5'd0) return 1'b0;
    if (BYP) begin
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_vld[p] && wb_idx[p*IDX_W +: IDX_W] == idx) return 1'b0;
    end
    return mb[inst][idx];
  endfunction

  task automatic idle();
    flush = 1'b0; issue_vld = 1'b0; issue_dst_idx = 5'd0;
    wb_vld = 2'b00; wb_idx = 10'd0; src_idx = 10'd0;
  endtask

  task automatic set_wb(input int p, input logic v, input logic [IDX_W-1:0] idx);
    wb_vld[p] = v;
    wb_idx[p*IDX_W +: IDX_W] = idx;
  endtask

  task automatic set_src(input int s, input logic [IDX_W-1:0] idx);
    src_idx[s*IDX_W +: IDX_W] = idx;
  endtask

  // Check combinational lookups away from the clock edge.
  task automatic eval();
    logic [SRC_NUM-1:0] e0, e1;
    @(negedge clk);
    for (int s = 0; s < SRC_NUM; s++) begin
      e0[s] = exp_lookup(0, src_idx[s*IDX_W +: IDX_W]);
      e1[s] = exp_lookup(1, src_idx[s*IDX_W +: IDX_W]);
    end
    chk("src_busy_r0", src_busy_a, e0);
    chk("src_busy_nz", src_busy_b, e1);
    chk("dst_busy_r0", dst_busy_a, (!cpurst && issue_dst_idx != 5'd0) ? mb[0][issue_dst_idx] : 1'b0);
    chk("dst_busy_nz", dst_busy_b, cpurst ? 1'b0 : mb[1][issue_dst_idx]);
  endtask

  // Advance the model at the edge, then check the registered table and count.
  task automatic tick();
    logic [REG_NUM-1:0] v;
    int c;
    @(posedge clk);
    for (int inst = 0; inst < 2; inst++) begin
      if (cpurst || flush) begin
        for (int k = 0; k < REG_NUM; k++) mb[inst][k] = 1'b0;
      end else begin
        for (int p = 0; p < WB_PORTS; p++)
          if (wb_vld[p]) mb[inst][wb_idx[p*IDX_W +: IDX_W]] = 1'b0;
        if (issue_vld) mb[inst][issue_dst_idx] = 1'b1;
        if (inst == 0) mb[0][0] = 1'b0;
      end
    end
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      c = 0;
      for (int k = 0; k < REG_NUM; k++) begin
        v[k] = mb[inst][k];
        c += int'(mb[inst][k]);
      end
      if (inst == 0) begin
        chk("busy_vec_r0", busy_vec_a, v);
        chk("busy_cnt_r0", busy_cnt_a, c);
      end else begin
        chk("busy_vec_nz", busy_vec_b, v);
        chk("busy_cnt_nz", busy_cnt_b, c);
      end
    end
  endtask

  function automatic logic [IDX_W-1:0] rnd_idx();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic rnd_inputs();
    issue_vld     = ($urandom_range(0, 3) != 0);
    issue_dst_idx = rnd_idx();
    for (int p = 0; p < WB_PORTS; p++) set_wb(p, ($urandom_range(0, 9) < 4), rnd_idx());
    for (int s = 0; s < SRC_NUM; s++) set_src(s, rnd_idx());
  endtask

  initial begin
    idle();
    cpurst = 1'b1;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      rnd_inputs();
      flush = 1'b0;
      eval();
      tick();
    end
    chk("rst_vec", busy_vec_a, 32'd0);
    chk("rst_cnt", busy_cnt_a, 6'd0);
    cpurst = 1'b0;
    idle();

    // Issue then lookup
    issue_vld = 1'b1; issue_dst_idx = 5'd5;
    eval(); tick();
    idle(); set_src(0, 5'd5); set_src(1, 5'd6);
    eval();
    chk("t2_src", src_busy_a, 2'b01);
    tick();
    chk("t2_cnt", busy_cnt_a, 6'd1);
    set_wb(1, 1'b1, 5'd5);
    eval(); tick();
    set_wb(1, 1'b0, 5'd0);
    eval();
    chk("t2_src_clr", src_busy_a, 2'b00);
    chk("t2_cnt_clr", busy_cnt_a, 6'd0);
    tick();

    // Set/clear collision
    idle(); issue_vld = 1'b1; issue_dst_idx = 5'd9;
    eval(); tick();
    set_wb(0, 1'b1, 5'd9);
    eval(); tick();
    chk("t3_bit9", busy_vec_a[9], 1'b1);
    chk("t3_cnt", busy_cnt_a, 6'd1);

    // x0 and full table
    idle(); issue_vld = 1'b1; issue_dst_idx = 5'd0;
    eval(); tick();
    chk("t4_r0_bit0", busy_vec_a[0], 1'b0);
    chk("t4_nz_bit0", busy_vec_b[0], 1'b1);
    for (int i = 1; i < 32; i++) begin
      issue_dst_idx = 5'(i);
      eval(); tick();
    end
    chk("t4_cnt_r0", busy_cnt_a, 6'd31);
    chk("t4_cnt_nz", busy_cnt_b, 6'd32);
    chk("t4_vec_nz", busy_vec_b, 32'hFFFF_FFFF);

    // Flush priority and mid-stream reset
    idle(); flush = 1'b1;
    eval(); tick();
    idle(); issue_vld = 1'b1;
    for (int i = 10; i < 20; i++) begin
      issue_dst_idx = 5'(i);
      eval(); tick();
    end
    chk("t5_cnt10", busy_cnt_a, 6'd10);
    flush = 1'b1; issue_dst_idx = 5'd3; set_wb(0, 1'b1, 5'd4);
    eval(); tick();
    chk("t5_flush_vec", busy_vec_a, 32'd0);
    chk("t5_flush_cnt", busy_cnt_b, 6'd0);
    idle(); issue_vld = 1'b1;
    issue_dst_idx = 5'd12; eval(); tick();
    issue_dst_idx = 5'd13; eval(); tick();
    cpurst = 1'b1; issue_dst_idx = 5'd14; set_src(0, 5'd12);
    eval();
    chk("t5_rst_src", src_busy_a, 2'b00);
    tick();
    chk("t5_rst_cnt", busy_cnt_a, 6'd0);
    cpurst = 1'b0;

    // Writeback bypass
    idle(); issue_vld = 1'b1; issue_dst_idx = 5'd7;
    eval(); tick();
    idle(); set_wb(0, 1'b1, 5'd7); set_src(0, 5'd7); set_src(1, 5'd7);
    eval();
    chk("t6_byp", src_busy_a, BYP ? 2'b00 : 2'b11);
    tick();
    set_wb(0, 1'b0, 5'd0);
    eval();
    chk("t6_after", src_busy_a, 2'b00);
    tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rnd_inputs();
      cpurst = ($urandom_range(0, 199) == 0);
      flush  = ($urandom_range(0, 49) == 0);
      eval();
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
